// File: rtl/pipe_mux_reg_if.sv
// Purpose : bundles the selector's channel bus, controls and registered outputs.
// Latency : n/a (wiring only).
// Backpressure : n/a; stall/flush travel as plain control inputs.
//
// Signals:
//   in_bus    packed channels, channel i = in_bus[i*WIDTH +: WIDTH]
//   sel       channel select (out-of-range values clamp to the last channel)
//   in_valid  selected data is valid
//   stall     hold register contents
//   flush     squash register to a bubble
//   out       registered selected data
//   out_valid registered valid
//   out_sel   registered effective (clamped) select
//   stall_cnt saturating count of stalled cycles with out_valid=1
//
// master : the side that drives channels and controls (upstream / hazard unit)
// slave  : the selector register itself
interface pipe_mux_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int CNT_W  = 8
);
  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    stall;
  logic                    flush;
  logic [WIDTH-1:0]        out;
  logic                    out_valid;
  logic [SEL_W-1:0]        out_sel;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output in_bus, sel, in_valid, stall, flush,
    input  out, out_valid, out_sel, stall_cnt
  );

  modport slave (
    input  in_bus, sel, in_valid, stall, flush,
    output out, out_valid, out_sel, stall_cnt
  );
endinterface

// File: rtl/pipe_mux_reg.sv
// Purpose : NUM_IN-way selector feeding a pipeline register with valid, stall and flush.
// Latency : 1 cycle from input sampling to registered outputs; no input-to-output comb path.
// Backpressure : stall holds the register (and counts stalled-valid cycles); flush squashes it.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous, active-high; clears data, valid, select and stall counter
//   bus    pipe_mux_reg_if.slave (channels, sel, in_valid, stall, flush in;
//          out, out_valid, out_sel, stall_cnt out)
module pipe_mux_reg #(
  parameter int              WIDTH     = 32,
  parameter int              NUM_IN    = 5,
  parameter int              CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  pipe_mux_reg_if.slave bus
);
  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1;

  logic [SEL_W-1:0] eff_sel;
  logic [WIDTH-1:0] sel_dat;

  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] out_sel_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Compare one bit wider so a power-of-two NUM_IN does not truncate to zero.
  always_comb begin
    eff_sel = bus.sel;
    if ({1'b0, bus.sel} >= (SEL_W + 1)'(NUM_IN))
      eff_sel = SEL_W'(NUM_IN - 1);
  end

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (eff_sel == SEL_W'(i))
        sel_dat = bus.in_bus[i*WIDTH +: WIDTH];
    end
  end

  // Priority: reset > flush > stall > load. Data loads even when in_valid=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= RESET_VAL;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else if (bus.flush) begin
      out_q       <= RESET_VAL;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
    end else if (bus.stall) begin
      // Only stalls that hold real data count; saturate at all-ones.
      if (out_valid_q && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end else begin
      out_q       <= sel_dat;
      out_valid_q <= bus.in_valid;
      out_sel_q   <= eff_sel;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_mux_reg.sv
// Directed bench for pipe_mux_reg: one instance with the default 8-bit stall
// counter and one with a 3-bit counter, both driven by the same stimulus.
module tb_pipe_mux_reg;
  localparam int              WIDTH  = 32;
  localparam int              NUM_IN = 5;
  localparam logic [31:0]     RV     = 32'h0BAD_F00D;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  pipe_mux_reg_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(8)) b8 ();
  pipe_mux_reg_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(3)) b3 ();

  assign b3.in_bus   = b8.in_bus;
  assign b3.sel      = b8.sel;
  assign b3.in_valid = b8.in_valid;
  assign b3.stall    = b8.stall;
  assign b3.flush    = b8.flush;

  pipe_mux_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(8), .RESET_VAL(RV)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  pipe_mux_reg #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .CNT_W(3), .RESET_VAL(RV)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks both instances; the counters are given separately since they saturate differently.
  task automatic chk_all(input string tag, input logic [31:0] e_out, input logic e_ov,
                         input logic [2:0] e_sel, input logic [7:0] e_c8, input logic [2:0] e_c3);
    chk({tag, ".out"},   b8.out,               e_out);
    chk({tag, ".ov"},    32'(b8.out_valid),    32'(e_ov));
    chk({tag, ".sel"},   32'(b8.out_sel),      32'(e_sel));
    chk({tag, ".cnt8"},  32'(b8.stall_cnt),    32'(e_c8));
    chk({tag, ".out3"},  b3.out,               e_out);
    chk({tag, ".cnt3"},  32'(b3.stall_cnt),    32'(e_c3));
  endtask

  task automatic set_ch(input logic [31:0] base);
    for (int i = 0; i < NUM_IN; i++)
      b8.in_bus[i*WIDTH +: WIDTH] = base + 32'(i);
  endtask

  // Advance one edge, then settle away from it before checking or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset       = 1'b1;
    b8.sel      = '0;
    b8.in_valid = 1'b0;
    b8.stall    = 1'b0;
    b8.flush    = 1'b0;
    set_ch(32'h1000);
    #2;
    step();
    chk_all("reset", RV, 1'b0, 3'd0, 8'd0, 3'd0);

    // Load channel 3.
    reset = 1'b0; b8.sel = 3'd3; b8.in_valid = 1'b1;
    step();
    chk_all("load3", 32'h1003, 1'b1, 3'd3, 8'd0, 3'd0);

    // Out-of-range selects clamp to the last channel.
    b8.sel = 3'd6;
    step();
    chk_all("clamp6", 32'h1004, 1'b1, 3'd4, 8'd0, 3'd0);
    b8.sel = 3'd7;
    step();
    chk_all("clamp7", 32'h1004, 1'b1, 3'd4, 8'd0, 3'd0);
    b8.sel = 3'd5;
    step();
    chk_all("clamp5", 32'h1004, 1'b1, 3'd4, 8'd0, 3'd0);

    // Load 0x1002 then stall four cycles while inputs wander.
    b8.sel = 3'd2;
    step();
    chk_all("load2", 32'h1002, 1'b1, 3'd2, 8'd0, 3'd0);
    b8.stall = 1'b1;
    set_ch(32'h2000);
    for (int k = 1; k <= 4; k++) begin
      b8.sel = 3'(k - 1);
      step();
      chk("stall.out", b8.out, 32'h1002);
      chk("stall.cnt", 32'(b8.stall_cnt), 32'(k));
    end
    chk_all("stall4", 32'h1002, 1'b1, 3'd2, 8'd4, 3'd4);
    b8.stall = 1'b0; b8.sel = 3'd1;
    step();
    chk_all("release", 32'h2001, 1'b1, 3'd1, 8'd4, 3'd4);

    // Flush beats stall and does not touch the counter.
    b8.stall = 1'b1; b8.flush = 1'b1;
    step();
    chk_all("flush", RV, 1'b0, 3'd0, 8'd4, 3'd4);
    b8.flush = 1'b0;
    step();
    chk_all("stall_inval", RV, 1'b0, 3'd0, 8'd4, 3'd4);

    // Saturation: 3-bit counter tops out at 7, 8-bit counter keeps going.
    b8.stall = 1'b0; b8.sel = 3'd0; b8.in_valid = 1'b1;
    step();
    chk_all("load0", 32'h2000, 1'b1, 3'd0, 8'd4, 3'd4);
    b8.stall = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("sat.cnt3", 32'(b3.stall_cnt), (k >= 3) ? 32'd7 : 32'(4 + k));
    end
    chk_all("sat", 32'h2000, 1'b1, 3'd0, 8'd14, 3'd7);

    // Reset mid-stream wins over a stall holding valid data.
    reset = 1'b1;
    step();
    chk_all("mid_reset", RV, 1'b0, 3'd0, 8'd0, 3'd0);

    // Invalid data still loads.
    reset = 1'b0; b8.stall = 1'b0; b8.in_valid = 1'b0; b8.sel = 3'd1;
    set_ch(32'h1000);
    step();
    chk_all("load_inval", 32'h1001, 1'b0, 3'd1, 8'd0, 3'd0);

    // Stall with out_valid=0 holds without counting.
    b8.stall = 1'b1; b8.sel = 3'd4;
    step();
    step();
    chk_all("stall_nocount", 32'h1001, 1'b0, 3'd1, 8'd0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
